// File: rtl/y86_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_mem_pkg
//  Description : Shared definitions for the Y86 data-memory responder:
//                FSM state encoding and default geometry/latency.
//  Revision    : 1.0  initial release
// ============================================================================
package y86_mem_pkg;

    // Default data-memory size in bytes (multiple of 8, >= 8)
    localparam int DMEM_MEM_BYTES_DEF = 1024;
    // Default cycles from request accept to response valid (1..15)
    localparam int DMEM_LATENCY_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage : y86_mem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Byte-addressed data memory with one 8-byte little-endian
//                port. Read is combinational, write is synchronous. Byte
//                lanes wrap from the top of the array back to address 0.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock
//    we_i     in   write the 8 bytes at base_i..base_i+7 on this edge
//    base_i   in   starting byte index, must already be < MEM_BYTES
//    wdata_i  in   store data, byte 0 at base_i
//    rdata_o  out  load data, byte 0 from base_i
// ============================================================================
module dmem_array
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = DMEM_MEM_BYTES_DEF
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [$clog2(MEM_BYTES)-1:0] base_i,
    input  logic [63:0]                  wdata_i,
    output logic [63:0]                  rdata_o
);

    localparam int IW = $clog2(MEM_BYTES);

    logic [7:0]    mem_q [MEM_BYTES];
    logic [IW:0]   w_sum [8];
    logic [IW-1:0] w_idx [8];

    // Lane i addresses base+i; one conditional subtract is enough because
    // base is in range and i <= 7 < MEM_BYTES.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = {1'b0, base_i} + (IW+1)'(i);
            if (w_sum[i] >= (IW+1)'(MEM_BYTES)) begin
                w_sum[i] = w_sum[i] - (IW+1)'(MEM_BYTES);
            end
            w_idx[i]           = w_sum[i][IW-1:0];
            rdata_o[8*i +: 8]  = mem_q[w_idx[i]];
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[w_idx[i]] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Y86 memory-stage data responder. Accepts one request at a
//                time, waits LATENCY cycles, performs the 8-byte access on
//                the edge entering RESP and holds the response until the
//                processor takes it.
//  Revision    : 1.0  initial release
//
//  Build option
//    DMEM_BOUNDS_CHECK_EN  defined: addr+7 >= MEM_BYTES (incl. 64-bit
//                          overflow) faults: resp_err=1, rdata=0, no write.
//                          undefined: resp_err=0, byte addresses wrap
//                          modulo MEM_BYTES.
//
//  Ports
//    clk, rst     clock, synchronous active-high reset
//    req_valid    in   request present          req_ready   out  IDLE
//    req_we       in   1=write 0=read           req_addr    in   byte addr
//    req_wdata    in   store data
//    resp_valid   out  response present         resp_ready  in   taken
//    resp_rdata   out  load data (0 on write)   resp_err    out  addr fault
// ============================================================================
module dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = DMEM_MEM_BYTES_DEF,
    parameter int LATENCY   = DMEM_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IW       = $clog2(MEM_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_acc_we;
    logic [63:0]   w_acc_addr;
    logic [63:0]   w_acc_wdata;
    logic          w_fault;
    logic [IW-1:0] w_base;
    logic [63:0]   w_arr_rdata;
    logic          w_mem_we;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign w_accept   = req_valid & req_ready;

    // With LATENCY=1 the access happens on the accept edge itself, before
    // the request is latched, so take the live inputs while in IDLE.
    assign w_acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign w_acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign w_acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_BOUNDS_CHECK_EN
    // 65-bit sum so an address near 2^64 overflows into a fault.
    logic [64:0] w_last;
    assign w_last  = {1'b0, w_acc_addr} + 65'd7;
    assign w_fault = (w_last >= 65'(MEM_BYTES));
    assign w_base  = w_acc_addr[IW-1:0];
`else
    assign w_fault = 1'b0;
    assign w_base  = IW'(w_acc_addr % 64'(MEM_BYTES));
`endif

    assign w_enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    // Reset on the would-be access edge abandons the write.
    assign w_mem_we     = w_enter_resp & w_acc_we & ~w_fault & ~rst;

    dmem_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clk     (clk),
        .we_i    (w_mem_we),
        .base_i  (w_base),
        .wdata_i (w_acc_wdata),
        .rdata_o (w_arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (w_enter_resp) begin
                rdata_q <= (w_acc_we | w_fault) ? 64'd0 : w_arr_rdata;
                err_q   <= w_fault;
            end
        end
    end

endmodule : dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, data-memory size in bytes (multiple of 8, >= 8).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid (legal range 1..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1: processor memory-stage request present.
REQ-005 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-006 SHALL have port req_we, input, 1: 1 = write (rmmovq/pushq/call), 0 = read (mrmovq/popq/ret).
REQ-007 SHALL have port req_addr, input, 64: byte address (valE or valA).
REQ-008 SHALL have port req_wdata, input, 64: store data (valA or valP).
REQ-009 SHALL have port resp_valid, output, 1: response present.
REQ-010 SHALL have port resp_ready, input, 1: processor accepts response.
REQ-011 SHALL have port resp_rdata, output, 64: load data (valM); 0 for writes.
REQ-012 SHALL have port resp_err, output, 1: address fault (maps to Y86 ADR status).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge with req_valid & req_ready, latching we, addr and wdata; go to WAIT with counter = LATENCY-1, or directly to RESP when LATENCY = 1.
REQ-015 SHALL decrement the counter each WAIT cycle and enter RESP on the edge the counter reaches 0; resp_valid rises exactly LATENCY cycles after accept.
REQ-016 SHALL perform the access on the edge entering RESP: 8 bytes little-endian, addr..addr+7; read fills resp_rdata, write updates the array.
REQ-017 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_valid & resp_ready, then return to IDLE on that edge.
REQ-018 SHALL not accept a new request in the return edge; next accept is earliest one cycle later (one outstanding request maximum).
REQ-019 SHALL allow unaligned addresses (no alignment fault).
REQ-020 SHALL ignore req_valid, req_we, req_addr and req_wdata changes in WAIT/RESP.
REQ-021 SHALL treat the final write data as committed even if resp_ready is held low indefinitely.

Reset
REQ-022 SHALL on rst: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, and req_ready 1 on the cycle after reset deasserts.
REQ-023 SHALL, on rst mid-operation (WAIT or RESP), abandon the request with no memory write if RESP was not yet entered.
REQ-024 SHALL not clear memory contents on rst.

Configuration
REQ-025 SHALL, with DMEM_BOUNDS_CHECK_EN defined, assert resp_err = 1 and suppress the write when addr + 7 >= MEM_BYTES (64-bit overflow counts as fault); resp_rdata = 0 on fault.
REQ-026 SHALL, without DMEM_BOUNDS_CHECK_EN, tie resp_err to 0 and compute each byte address modulo MEM_BYTES (wrap-around).

Structure
REQ-027 SHALL place the FSM state enum, the default MEM_BYTES and the default LATENCY in shared package y86_mem_pkg.
REQ-028 SHALL keep the byte array as sub-module dmem_array: 8-byte little-endian read/write port with a synchronous write.

Verification
REQ-029 SHALL cover: reset, then write addr 0x40, data 0x1122334455667788, LATENCY 2 -> resp_valid at accept+2, resp_rdata 0, resp_err 0.
REQ-030 SHALL cover: read addr 0x40 after REQ-029 -> resp_rdata 0x1122334455667788; read addr 0x41 -> 0x??11223344556677, where the top byte is the byte at 0x48.
REQ-031 SHALL cover: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable; req_ready 0 throughout; IDLE one edge after the handshake.
REQ-032 SHALL cover: read addr 1020, MEM_BYTES 1024 -> with macro, resp_err 1 and rdata 0; without macro, bytes 1020..1023 then 0..3.
REQ-033 SHALL cover: rst asserted in WAIT of a write to 0x80 -> location 0x80 unchanged on later read, resp_valid 0, req_ready 1.
REQ-034 SHALL cover: LATENCY 1, back-to-back requests with resp_ready tied 1 -> one response every 2 cycles, in order.
